// File: rtl/psum_ctrl_pkg.sv
// Shared types for the psum adder-tree sequencer: FSM state encoding,
// the per-beat tag that rides alongside the adder tree, and the fixed
// adder latency.
package psum_ctrl_pkg;

  // Adder tree latency from PE data to adder output, in cycles.
  localparam int LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Position tag of one PE beat; all-zero encodes a bubble.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
    logic eol;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  // Saturating 32-bit increment used by the optional perf counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/psum_tag_pipe.sv
// LAT-deep shift register carrying beat tags in lockstep with the adder
// tree. Advances every cycle; bubbles enter as all-zero tags. Every stage
// is exposed so the controller can pick the tap matching each strobe.
module psum_tag_pipe
  import psum_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  tag_t                    tag_in,
  output tag_t [DEPTH-1:0]        taps
);

  tag_t [DEPTH-1:0] pipe_q;
  tag_t [DEPTH-1:0] pipe_d;

  // Shift every stage by one and load the new tag into stage 0.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipe register; reset flushes every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign taps = pipe_q;

endmodule

// File: rtl/psum_add_ctrl.sv
// Sequencer for the 3-stage psum adder tree. Tracks the column/channel
// position of each PE beat and drives the psum FIFO pop, the zero-select
// mux and the FIFO push / final-output strobes, each aligned with the
// adder stage that consumes it.
// Optional feature macro: PSUM_CTRL_PERF_EN adds perf_run_cyc/perf_beats.
module psum_add_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int COL_W = 8,
  parameter int CHN_W = 10,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] cfg_cols,
  input  logic [CHN_W-1:0] cfg_chans,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  input  logic             pe_valid,
  output logic             fifo_rd_en,
  output logic             fifo_sel_zero,
  output logic             fifo_wr_en,
  output logic             out_valid,
  output logic             out_last
`ifdef PSUM_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_run_cyc,
  output logic [31:0]      perf_beats
`endif
);

  // The strobe taps below are hard-wired to a 3-stage tree.
  if (LAT != 3) begin : g_lat_check
    $error("psum_add_ctrl: LAT must be 3");
  end

  state_t           state_q,   state_d;
  logic [COL_W-1:0] cols_q,    cols_d;
  logic [CHN_W-1:0] chans_q,   chans_d;
  logic [COL_W-1:0] col_q,     col_d;
  logic [CHN_W-1:0] chn_q,     chn_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_ok;
  logic             start_ok;
  logic             beat;
  logic             last_col;
  logic             last_chn;
  logic             drained;
  tag_t             tag_in;
  tag_t [LAT-1:0]   taps;
  logic             unused_tap_first;

  // Start qualification, beat acceptance and position decode of the current beat.
  always_comb begin
    cfg_ok   = (cfg_cols >= COL_W'(3)) && (cfg_chans != '0);
    start_ok = start && (state_q == IDLE) && cfg_ok;
    beat     = pe_valid && (state_q == RUN);
    last_col = (col_q == cols_q - COL_W'(1));
    last_chn = (chn_q == chans_q - CHN_W'(1));
  end

  // Build the tag for this cycle; a non-beat cycle inserts an all-zero bubble.
  always_comb begin
    tag_in       = TAG_NONE;
    tag_in.vld   = beat;
    tag_in.first = beat && (chn_q == '0);
    tag_in.last  = beat && last_chn;
    tag_in.eol   = beat && last_col;
  end

  psum_tag_pipe #(
    .DEPTH (LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .taps   (taps)
  );

  // The tree is empty after this cycle once every stage but the last holds a bubble.
  always_comb begin
    drained = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      if (taps[i] != TAG_NONE) begin
        drained = 1'b0;
      end
    end
  end

  // Next-state logic: RUN until the final beat, DRAIN until the pipe empties, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat && last_col && last_chn) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Config capture on an accepted start, column/channel counting per beat, reject flag.
  always_comb begin
    cols_d    = cols_q;
    chans_d   = chans_q;
    col_d     = col_q;
    chn_d     = chn_q;
    cfg_err_d = start && (state_q == IDLE) && !cfg_ok;
    if (start_ok) begin
      cols_d  = cfg_cols;
      chans_d = cfg_chans;
      col_d   = '0;
      chn_d   = '0;
    end else if (beat) begin
      if (last_col) begin
        col_d = '0;
        chn_d = chn_q + CHN_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cols_q    <= '0;
      chans_q   <= '0;
      col_q     <= '0;
      chn_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cols_q    <= cols_d;
      chans_q   <= chans_d;
      col_q     <= col_d;
      chn_q     <= chn_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Strobes read from the tap aligned with each adder stage: pop at t+1, zero-mux at t+2, result at t+3.
  always_comb begin
    busy          = (state_q == RUN) || (state_q == DRAIN);
    done          = (state_q == DONE);
    cfg_err       = cfg_err_q;
    fifo_rd_en    = taps[0].vld && !taps[0].first;
    fifo_sel_zero = taps[1].vld && taps[1].first;
    fifo_wr_en    = taps[LAT-1].vld && !taps[LAT-1].last;
    out_valid     = taps[LAT-1].vld && taps[LAT-1].last;
    out_last      = taps[LAT-1].vld && taps[LAT-1].last && taps[LAT-1].eol;
  end

  // The first flag has no consumer once the tag reaches the adder output.
  assign unused_tap_first = taps[LAT-1].first;

`ifdef PSUM_CTRL_PERF_EN
  logic [31:0] perf_run_cyc_q, perf_run_cyc_d;
  logic [31:0] perf_beats_q,   perf_beats_d;

  // Saturating activity counters, cleared by an accepted start and frozen outside RUN/DRAIN.
  always_comb begin
    perf_run_cyc_d = perf_run_cyc_q;
    perf_beats_d   = perf_beats_q;
    if (start_ok) begin
      perf_run_cyc_d = '0;
      perf_beats_d   = '0;
    end else begin
      if (busy) begin
        perf_run_cyc_d = sat_inc(perf_run_cyc_q);
      end
      if (beat) begin
        perf_beats_d = sat_inc(perf_beats_q);
      end
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_run_cyc_q <= '0;
      perf_beats_q   <= '0;
    end else begin
      perf_run_cyc_q <= perf_run_cyc_d;
      perf_beats_q   <= perf_beats_d;
    end
  end

  assign perf_run_cyc = perf_run_cyc_q;
  assign perf_beats   = perf_beats_q;
`endif

endmodule

// File: tb/tb_psum_add_ctrl.sv
// Self-checking bench for psum_add_ctrl. The stimulus side models each
// beat's column/channel position and queues the cycle at which every
// strobe must appear; a negedge monitor pops and compares each cycle.
module tb_psum_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_cols;
  logic [9:0]  cfg_chans;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        pe_valid;
  logic        fifo_rd_en;
  logic        fifo_sel_zero;
  logic        fifo_wr_en;
  logic        out_valid;
  logic        out_last;
`ifdef PSUM_CTRL_PERF_EN
  logic [31:0] perf_run_cyc;
  logic [31:0] perf_beats;
`endif

  psum_add_ctrl #(
    .COL_W (8),
    .CHN_W (10),
    .LAT   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_cols      (cfg_cols),
    .cfg_chans     (cfg_chans),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .pe_valid      (pe_valid),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_sel_zero (fifo_sel_zero),
    .fifo_wr_en    (fifo_wr_en),
    .out_valid     (out_valid),
    .out_last      (out_last)
`ifdef PSUM_CTRL_PERF_EN
    ,
    .perf_run_cyc  (perf_run_cyc),
    .perf_beats    (perf_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit eol;
  } out_ev_t;

  int      rd_q[$];
  int      sel_q[$];
  int      wr_q[$];
  out_ev_t out_q[$];

  int exp_done_cyc = -1;
  int exp_err_cyc  = -1;
  int m_busy_from  = -1;
  int m_busy_to    = -2;
  int m_cols, m_chans, m_col, m_chn;
  int m_start_cyc, m_last_cyc;
  bit m_run = 1'b0;
  bit mon_en = 1'b0;

  int n_rd, n_sel, n_wr, n_out, n_last, n_err;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Per-cycle monitor: every strobe is compared against the scoreboard every cycle.
  always @(negedge clk) begin : monitor
    bit e_rd, e_sel, e_wr, e_ov, e_ol;
    if (mon_en) begin
      e_rd  = (rd_q.size()  > 0) && (rd_q[0]  == cyc);
      e_sel = (sel_q.size() > 0) && (sel_q[0] == cyc);
      e_wr  = (wr_q.size()  > 0) && (wr_q[0]  == cyc);
      e_ov  = (out_q.size() > 0) && (out_q[0].cyc == cyc);
      e_ol  = e_ov && out_q[0].eol;
      if (e_rd)  void'(rd_q.pop_front());
      if (e_sel) void'(sel_q.pop_front());
      if (e_wr)  void'(wr_q.pop_front());
      if (e_ov)  void'(out_q.pop_front());
      checkOutput("fifo_rd_en",    fifo_rd_en,    e_rd);
      checkOutput("fifo_sel_zero", fifo_sel_zero, e_sel);
      checkOutput("fifo_wr_en",    fifo_wr_en,    e_wr);
      checkOutput("out_valid",     out_valid,     e_ov);
      checkOutput("out_last",      out_last,      e_ol);
      checkOutput("done",          done,          cyc == exp_done_cyc);
      checkOutput("cfg_err",       cfg_err,       cyc == exp_err_cyc);
      checkOutput("busy",          busy,          (cyc >= m_busy_from) && (cyc <= m_busy_to));
      if (fifo_rd_en)    n_rd++;
      if (fifo_sel_zero) n_sel++;
      if (fifo_wr_en)    n_wr++;
      if (out_valid)     n_out++;
      if (out_last)      n_last++;
      if (cfg_err)       n_err++;
    end
  end

  // Drive one cycle of pe_valid; a beat accepted in RUN queues its expected strobes.
  task automatic applyStimulus(input bit valid);
    bit first, last, eol;
    out_ev_t ev;
    pe_valid = valid;
    if (valid && m_run) begin
      first = (m_chn == 0);
      last  = (m_chn == m_chans - 1);
      eol   = (m_col == m_cols - 1);
      if (!first) rd_q.push_back(cyc + 1);
      if (first)  sel_q.push_back(cyc + 2);
      if (!last) begin
        wr_q.push_back(cyc + 3);
      end else begin
        ev.cyc = cyc + 3;
        ev.eol = eol;
        out_q.push_back(ev);
      end
      if (eol) begin
        m_col = 0;
        m_chn++;
      end else begin
        m_col++;
      end
      if (last && eol) begin
        m_run        = 1'b0;
        m_last_cyc   = cyc;
        m_busy_to    = cyc + 3;
        exp_done_cyc = cyc + 4;
      end
    end
    @(posedge clk);
    #1;
    pe_valid = 1'b0;
  endtask

  // Pulse start with a configuration; the model follows accept/reject.
  task automatic startRun(input int cols, input int chans);
    n_rd = 0; n_sel = 0; n_wr = 0; n_out = 0; n_last = 0; n_err = 0;
    start     = 1'b1;
    cfg_cols  = 8'(cols);
    cfg_chans = 10'(chans);
    if (cols >= 3 && chans != 0) begin
      m_run       = 1'b1;
      m_cols      = cols;
      m_chans     = chans;
      m_col       = 0;
      m_chn       = 0;
      m_start_cyc = cyc;
      m_busy_from = cyc + 1;
      m_busy_to   = 32'h7FFF_FFFF;
    end else begin
      exp_err_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Idle until the expected done pulse has passed, then compare run totals.
  task automatic finishRun(input int e_rd, input int e_sel, input int e_wr, input int e_out);
    for (int i = 0; i < 200 && cyc <= exp_done_cyc; i++) applyStimulus(1'b0);
    checkOutput("done_reached", cyc > exp_done_cyc, 1);
    checkOutput("n_fifo_rd_en",    n_rd,   e_rd);
    checkOutput("n_fifo_sel_zero", n_sel,  e_sel);
    checkOutput("n_fifo_wr_en",    n_wr,   e_wr);
    checkOutput("n_out_valid",     n_out,  e_out);
    checkOutput("n_out_last",      n_last, 1);
    checkOutput("sb_leftover", rd_q.size() + sel_q.size() + wr_q.size() + out_q.size(), 0);
  endtask

  // Synchronous reset for one cycle; anything expected after it is discarded.
  task automatic resetDut();
    rst = 1'b1;
    while (rd_q.size()  > 0 && rd_q[$]  > cyc) void'(rd_q.pop_back());
    while (sel_q.size() > 0 && sel_q[$] > cyc) void'(sel_q.pop_back());
    while (wr_q.size()  > 0 && wr_q[$]  > cyc) void'(wr_q.pop_back());
    while (out_q.size() > 0 && out_q[$].cyc > cyc) void'(out_q.pop_back());
    if (exp_done_cyc > cyc) exp_done_cyc = -1;
    if (m_busy_to > cyc) m_busy_to = cyc;
    m_run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_rd = 0; n_sel = 0; n_wr = 0; n_out = 0; n_last = 0; n_err = 0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pe_valid  = 1'b0;
    cfg_cols  = '0;
    cfg_chans = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs",
                {busy, done, cfg_err, fifo_rd_en, fifo_sel_zero, fifo_wr_en, out_valid, out_last}, 8'h00);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: cols=4 chans=1 back-to-back");
    startRun(4, 1);
    repeat (4) applyStimulus(1'b1);
    finishRun(0, 4, 0, 4);

    $display("[TB] test 2: cols=3 chans=3 contiguous");
    startRun(3, 3);
    repeat (9) applyStimulus(1'b1);
    finishRun(6, 3, 6, 3);

    $display("[TB] test 3: cols=5 chans=2 alternating valid");
    startRun(5, 2);
    repeat (10) begin
      applyStimulus(1'b1);
      applyStimulus(1'b0);
    end
    finishRun(5, 5, 5, 5);

    $display("[TB] test 4: rejected configurations");
    startRun(2, 1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    startRun(3, 0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("n_cfg_err", n_err, 1);
    checkOutput("rejected_no_strobes", n_rd + n_sel + n_wr + n_out, 0);
    startRun(3, 1);
    repeat (3) applyStimulus(1'b1);
    finishRun(0, 3, 0, 3);

    $display("[TB] test 5: reset mid-run");
    startRun(4, 3);
    repeat (5) applyStimulus(1'b1);
    resetDut();
    @(negedge clk);
    checkOutput("post_reset_outputs",
                {busy, done, cfg_err, fifo_rd_en, fifo_sel_zero, fifo_wr_en, out_valid, out_last}, 8'h00);
    @(posedge clk);
    #1;
    repeat (6) applyStimulus(1'b1);
    checkOutput("ignored_beats", n_rd + n_sel + n_wr + n_out, 0);
    startRun(3, 1);
    repeat (3) applyStimulus(1'b1);
    finishRun(0, 3, 0, 3);

`ifdef PSUM_CTRL_PERF_EN
    $display("[TB] test 6: perf counters");
    startRun(4, 2);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    finishRun(4, 4, 4, 4);
    checkOutput("perf_beats",   perf_beats,   8);
    checkOutput("perf_run_cyc", perf_run_cyc, m_last_cyc - m_start_cyc + 3);
    repeat (3) applyStimulus(1'b1);
    checkOutput("perf_beats_hold",   perf_beats,   8);
    checkOutput("perf_run_cyc_hold", perf_run_cyc, m_last_cyc - m_start_cyc + 3);
`endif

    repeat (2) applyStimulus(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
